// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive engine (optional UART_RX_PARITY_EN)
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_W     = 27;
    localparam int UART_MIN_DIV   = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP1,
        RX_STOP2
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with a parameterised reset value
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    // Shift the asynchronous input through two flops; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {2{RST_VAL}};
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive engine, 8N1/8N2 with optional parity (UART_RX_PARITY_EN)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DIV_W     = UART_DIV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 two_stop_bits,
    input  logic                 s_in,
    input  logic                 rd_ack,
    input  logic                 err_clr,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_complete,
    output logic                 busy_rx,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 s_sync;
    logic                 s_prev;
    logic                 fall;
    logic                 tick;
    logic                 frame_done;
    logic                 stop_sample;
    logic                 fin;
    logic [DIV_W-1:0]     div_eff;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift_q;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (s_in),
        .q   (s_sync)
    );

    assign fall        = s_prev & ~s_sync;
    assign tick        = (bit_cnt == '0);
    assign div_eff     = (baud_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : baud_div;
    assign stop_sample = en && tick && (state == RX_STOP1 || state == RX_STOP2);
    assign frame_done  = en && tick && ((state == RX_STOP1 && !two_stop_bits) || state == RX_STOP2);
    assign busy_rx     = (state != RX_IDLE);
    assign rx_complete = fin;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a dropped enable overrides everything and parks the FSM in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = s_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = RX_PARITY;
`else
                    state_nxt = RX_STOP1;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: if (tick) state_nxt = RX_STOP1;
`endif
            RX_STOP1: if (tick) state_nxt = two_stop_bits ? RX_STOP2 : RX_IDLE;
            RX_STOP2: if (tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
        if (!en) state_nxt = RX_IDLE;
    end

    // Bit timing, data shift register and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_prev  <= 1'b1;
            div_q   <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            shift_q <= '0;
            fin     <= 1'b0;
        end else begin
            s_prev <= s_sync;
            fin    <= frame_done;
            if (!tick) bit_cnt <= bit_cnt - 1'b1;
            if (en) begin
                case (state)
                    RX_IDLE: begin
                        if (fall) begin
                            div_q   <= div_eff;
                            bit_cnt <= div_eff >> 1;
                        end
                    end
                    RX_START: begin
                        if (tick && !s_sync) begin
                            bit_cnt <= div_q - 1'b1;
                            idx     <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            shift_q <= {s_sync, shift_q[DATA_BITS-1:1]};
                            bit_cnt <= div_q - 1'b1;
                            idx     <= idx + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    RX_PARITY: if (tick) bit_cnt <= div_q - 1'b1;
`endif
                    RX_STOP1: if (tick && two_stop_bits) bit_cnt <= div_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Byte hand-off, CPU acknowledge and sticky error flags; a set always beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fin) begin
                if (!rx_valid || rd_ack) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end
            end else if (rd_ack) begin
                rx_valid <= 1'b0;
            end

            if (fin && rx_valid && !rd_ack) overrun <= 1'b1;
            else if (err_clr)               overrun <= 1'b0;

            if (stop_sample && !s_sync) frame_err <= 1'b1;
            else if (err_clr)           frame_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    assign par_bad = en && tick && (state == RX_PARITY) && (s_sync != ((^shift_q) ^ parity_odd));

    // Sticky parity mismatch flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (par_bad) begin
            parity_err <= 1'b1;
        end else if (err_clr) begin
            parity_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl (optional UART_RX_PARITY_EN)
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [26:0] baud_div = 27'd10;
    logic        two_stop_bits = 1'b0;
    logic        s_in = 1'b1;
    logic        rd_ack;
    logic        ack_mon = 1'b0;
    logic        ack_tst = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_complete, busy_rx, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd = 1'b0;
    logic        parity_err;
`endif

    int          tests = 0;
    int          fails = 0;
    int          completes = 0;
    int          busy_cycles = 0;
    int          div = 10;
    logic        ack_on_finish = 1'b0;
    logic [7:0]  exp_q[$];

    assign rd_ack = ack_mon | ack_tst;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .baud_div      (baud_div),
        .two_stop_bits (two_stop_bits),
        .s_in          (s_in),
        .rd_ack        (rd_ack),
        .err_clr       (err_clr),
`ifdef UART_RX_PARITY_EN
        .parity_odd    (parity_odd),
        .parity_err    (parity_err),
`endif
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_complete   (rx_complete),
        .busy_rx       (busy_rx),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    // Scoreboard: every rx_complete pops one expected byte, checked the cycle after.
    initial begin
        logic       pending;
        logic [7:0] e;
        pending = 1'b0;
        e = 8'h00;
        forever begin
            @(negedge clk);
            if (busy_rx === 1'b1) busy_cycles++;
            if (pending) begin
                pending = 1'b0;
                ack_mon = 1'b0;
                tests++;
                if (rx_data !== e || rx_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL scoreboard: rx_data=%h rx_valid=%b, expected rx_data=%h rx_valid=1", rx_data, rx_valid, e);
                end
            end
            if (rx_complete === 1'b1) begin
                completes++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_complete: rx_complete=1, expected no frame");
                end else begin
                    e = exp_q.pop_front();
                    pending = 1'b1;
                    if (ack_on_finish) ack_mon = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        s_in = v;
        repeat (div) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack_tst = 1'b1;
        idle(1);
        ack_tst = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    // Sends one frame; mid_div != 0 rewrites baud_div right after the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop2_low, input logic par_flip, input int mid_div);
        send_bit(1'b0);
        if (mid_div != 0) baud_div = 27'(mid_div);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ parity_odd ^ par_flip);
`endif
        send_bit(1'b1);
        if (two_stop_bits) send_bit(~stop2_low);
        s_in = 1'b1;
        idle(div);
    endtask

    task automatic test_reset();
        idle(3);
        tests++;
        if ({rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: outputs=%h, expected 0", {rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun});
        end
        rst = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int c0;
        div = 10; baud_div = 27'd10;
        c0 = completes;
        busy_cycles = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        tests++;
        if (completes !== c0 + 1) begin
            fails++; $display("FAIL basic_pulses: completes=%0d, expected %0d", completes - c0, 1);
        end
        tests++;
        if (frame_err !== 1'b0 || rx_valid !== 1'b1) begin
            fails++; $display("FAIL basic_flags: frame_err=%b rx_valid=%b, expected 0/1", frame_err, rx_valid);
        end
        tests++;
        if (busy_cycles < 90 || busy_cycles > 100) begin
            fails++; $display("FAIL basic_busy: busy cycles=%0d, expected 90..100", busy_cycles);
        end
    endtask

    task automatic test_glitch();
        int c0;
        pulse_ack();
        c0 = completes;
        s_in = 1'b0;
        idle(3);
        s_in = 1'b1;
        idle(3);
        tests++;
        if (busy_rx !== 1'b1) begin
            fails++; $display("FAIL glitch_detect: busy_rx=%b, expected 1", busy_rx);
        end
        idle(10);
        tests++;
        if (busy_rx !== 1'b0 || rx_valid !== 1'b0 || completes !== c0) begin
            fails++; $display("FAIL glitch_abort: busy_rx=%b rx_valid=%b completes=%0d, expected 0/0/0", busy_rx, rx_valid, completes - c0);
        end
    endtask

    task automatic test_two_stop();
        two_stop_bits = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        tests++;
        if (frame_err !== 1'b1) begin
            fails++; $display("FAIL stop2_frame_err: frame_err=%b, expected 1", frame_err);
        end
        pulse_clr();
        tests++;
        if (frame_err !== 1'b0) begin
            fails++; $display("FAIL err_clr: frame_err=%b, expected 0", frame_err);
        end
        two_stop_bits = 1'b0;
        pulse_ack();
    endtask

    task automatic test_overrun();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h22, 1'b0, 1'b0, 0);
        tests++;
        if (overrun !== 1'b1) begin
            fails++; $display("FAIL overrun_set: overrun=%b, expected 1", overrun);
        end
        pulse_clr();
        ack_on_finish = 1'b1;
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b0, 1'b0, 0);
        ack_on_finish = 1'b0;
        tests++;
        if (overrun !== 1'b0 || rx_valid !== 1'b1) begin
            fails++; $display("FAIL ack_on_finish: overrun=%b rx_valid=%b, expected 0/1", overrun, rx_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tests++;
        if (busy_rx !== 1'b1) begin
            fails++; $display("FAIL mid_frame_busy: busy_rx=%b, expected 1", busy_rx);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun} !== 13'h0) begin
            fails++; $display("FAIL async_reset: outputs=%h, expected 0", {rx_data, rx_valid, rx_complete, busy_rx, frame_err, overrun});
        end
        s_in = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(5);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
    endtask

    task automatic test_en_abort();
        int   c0;
        logic v0;
        c0 = completes;
        v0 = rx_valid;
        send_bit(1'b0);
        send_bit(1'b1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy_rx !== 1'b0) begin
            fails++; $display("FAIL en_abort_busy: busy_rx=%b, expected 0", busy_rx);
        end
        idle(1);
        idle(10 * div);
        en = 1'b1;
        idle(div);
        tests++;
        if (completes !== c0 || rx_valid !== v0 || rx_data !== 8'h5A) begin
            fails++; $display("FAIL en_abort_hold: completes=%0d rx_valid=%b rx_data=%h, expected 0/%b/5a", completes - c0, rx_valid, rx_data, v0);
        end
        pulse_ack();
    endtask

    task automatic test_div_change();
        div = 7; baud_div = 27'd7;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0, 0);
        pulse_ack();
        div = 10; baud_div = 27'd10;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0, 1'b0, 3);
        baud_div = 27'd10;
        pulse_ack();
    endtask

    task automatic test_patterns();
        logic [7:0] b;
        div = 16; baud_div = 27'd16;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b0, 1'b0, 0);
            pulse_ack();
        end
        tests++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            fails++; $display("FAIL patterns_flags: frame_err=%b overrun=%b, expected 0/0", frame_err, overrun);
        end
        div = 10; baud_div = 27'd10;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        parity_odd = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b1, 0);
        tests++;
        if (parity_err !== 1'b1) begin
            fails++; $display("FAIL parity_err: parity_err=%b, expected 1", parity_err);
        end
        pulse_clr();
        pulse_ack();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_two_stop();
        test_overrun();
        pulse_ack();
        test_reset_mid();
        test_en_abort();
        test_div_change();
        test_patterns();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        idle(20);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
